// File: rtl/count_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : count_decoder                                                |
// | Description : Recovers the en bit stream from an up/down counter by        |
// |               classifying successive count deltas (+INC -> 1, -DEC -> 0),  |
// |               packs bits LSB-first into OUT_W-bit words with a valid/ready |
// |               output stage, and flags illegal deltas.                      |
// |               Optional macro COUNT_DECODER_ERRCNT_EN adds a 16-bit         |
// |               saturating err_count output.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module count_decoder #(
   parameter int WIDTH = 8,
   parameter int INC   = 5,
   parameter int DEC   = 1,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count_in,
   input  logic             count_valid,
   output logic             bit_out,
   output logic             bit_valid,
   output logic [OUT_W-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             locked,
   output logic             err,
   output logic             overflow
`ifdef COUNT_DECODER_ERRCNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   localparam int               CNT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   // Deltas are compared modulo 2^WIDTH, so both legal steps are folded into WIDTH bits.
   localparam logic [WIDTH-1:0] C_INC  = WIDTH'(INC);
   localparam logic [WIDTH-1:0] C_NDEC = WIDTH'(-DEC);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(OUT_W - 1);

   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   state_t             state_q,      state_d;
   logic [WIDTH-1:0]   prev_q,       prev_d;
   logic [CNT_W-1:0]   bitcnt_q,     bitcnt_d;
   logic [OUT_W-1:0]   shreg_q,      shreg_d;
   logic               bit_out_q,    bit_out_d;
   logic               bit_valid_q,  bit_valid_d;
   logic [OUT_W-1:0]   word_q,       word_d;
   logic               word_valid_q, word_valid_d;
   logic               err_q,        err_d;
   logic               overflow_q,   overflow_d;

   logic [WIDTH-1:0]   w_delta;
   logic               w_is_one;
   logic               w_is_zero;
   logic               w_legal;
   logic               w_accept;
   logic [OUT_W-1:0]   w_word_new;

   assign w_delta   = count_in - prev_q;
   assign w_is_one  = (w_delta == C_INC);
   assign w_is_zero = (w_delta == C_NDEC);
   assign w_legal   = w_is_one | w_is_zero;
   assign w_accept  = word_valid_q & word_ready;

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_UNLOCKED;
         prev_q       <= '0;
         bitcnt_q     <= '0;
         shreg_q      <= '0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         err_q        <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         bitcnt_q     <= bitcnt_d;
         shreg_q      <= shreg_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         err_q        <= err_d;
         overflow_q   <= overflow_d;
      end
   end

   // Next-state: lock on first sample, then classify each delta and assemble words.
   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      bitcnt_d     = bitcnt_q;
      shreg_d      = shreg_q;
      bit_out_d    = bit_out_q;
      bit_valid_d  = 1'b0;
      word_d       = word_q;
      word_valid_d = word_valid_q;
      err_d        = 1'b0;
      overflow_d   = overflow_q;
      w_word_new   = shreg_q;

      // A consumed word frees the output register unless a new word refills it below.
      if (w_accept) begin
         word_valid_d = 1'b0;
      end

      case (state_q)
         ST_UNLOCKED: begin
            if (count_valid) begin
               prev_d  = count_in;
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (count_valid) begin
               prev_d = count_in;
               if (w_legal) begin
                  bit_out_d            = w_is_one;
                  bit_valid_d          = 1'b1;
                  w_word_new[bitcnt_q] = w_is_one;
                  if (bitcnt_q == C_LAST) begin
                     bitcnt_d = '0;
                     shreg_d  = '0;
                     // Load only when the output register is empty or draining this cycle.
                     if (!word_valid_q || w_accept) begin
                        word_d       = w_word_new;
                        word_valid_d = 1'b1;
                     end else begin
                        overflow_d = 1'b1;
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + 1'b1;
                     shreg_d  = w_word_new;
                  end
               end else begin
                  // Resynchronise on the new sample; a zero count is an upstream reset, not an error.
                  bitcnt_d = '0;
                  shreg_d  = '0;
                  if (count_in != '0) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_UNLOCKED;
         end
      endcase
   end

`ifdef COUNT_DECODER_ERRCNT_EN
   logic [15:0] err_count_q;

   // Saturating count of reported errors (upstream resets never raise err_d).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_q <= '0;
      end else if (err_d && (err_count_q != 16'hFFFF)) begin
         err_count_q <= err_count_q + 16'd1;
      end
   end

   assign err_count = err_count_q;
`endif

   assign bit_out    = bit_out_q;
   assign bit_valid  = bit_valid_q;
   assign word_out   = word_q;
   assign word_valid = word_valid_q;
   assign locked     = (state_q == ST_LOCKED);
   assign err        = err_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_count_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_count_decoder                                             |
// | Description : Directed self-checking bench for count_decoder.              |
// |               Covers COUNT_DECODER_ERRCNT_EN when that macro is defined.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_count_decoder;

   localparam int P_WIDTH = 8;
   localparam int P_INC   = 5;
   localparam int P_DEC   = 1;
   localparam int P_OUT_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [P_WIDTH-1:0] count_in;
   logic               count_valid;
   logic               bit_out;
   logic               bit_valid;
   logic [P_OUT_W-1:0] word_out;
   logic               word_valid;
   logic               word_ready;
   logic               locked;
   logic               err;
   logic               overflow;
`ifdef COUNT_DECODER_ERRCNT_EN
   logic [15:0]        err_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   count_decoder #(
      .WIDTH (P_WIDTH),
      .INC   (P_INC),
      .DEC   (P_DEC),
      .OUT_W (P_OUT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .count_in    (count_in),
      .count_valid (count_valid),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .locked      (locked),
      .err         (err),
      .overflow    (overflow)
`ifdef COUNT_DECODER_ERRCNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   // Present one valid sample for one cycle; returns 1 ns after the capturing edge.
   task automatic step(input int v);
      @(negedge clk);
      count_in    = P_WIDTH'(v);
      count_valid = 1'b1;
      @(posedge clk);
      #1;
      count_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      count_in    = '0;
      count_valid = 1'b0;
      word_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({bit_out, bit_valid, word_valid, locked, err, overflow} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags got=%b want=000000",
                  {bit_out, bit_valid, word_valid, locked, err, overflow});
      end
      n_cmp++;
      if (word_out !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_word got=%h want=00", word_out);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int s[9] = '{0, 5, 4, 9, 8, 13, 12, 17, 16};
      do_reset();
      word_ready = 1'b1;
      step(s[0]);
      n_cmp++;
      if ({locked, bit_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL basic_lock got locked,bit_valid=%b want=10", {locked, bit_valid});
      end
      for (int i = 1; i < 9; i++) begin
         logic exp_bit;
         exp_bit = (i % 2 == 1);
         step(s[i]);
         n_cmp++;
         if ({bit_valid, bit_out, err, word_valid} !== {1'b1, exp_bit, 1'b0, (i == 8)}) begin
            n_bad++;
            $display("FAIL basic_bit%0d got v,b,e,wv=%b want=%b", i,
                     {bit_valid, bit_out, err, word_valid}, {1'b1, exp_bit, 1'b0, (i == 8)});
         end
      end
      n_cmp++;
      if (word_out !== 8'h55) begin
         n_bad++;
         $display("FAIL basic_word got=%h want=55", word_out);
      end
      idle(1);
      n_cmp++;
      if ({word_valid, bit_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_accept got wv,bv=%b want=00", {word_valid, bit_valid});
      end
   endtask

   task automatic test_wrap();
      int   s[5]   = '{125, -126, -127, -128, 127};
      logic eb[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      step(120);
      for (int i = 0; i < 5; i++) begin
         step(s[i]);
         n_cmp++;
         if ({bit_valid, bit_out, err} !== {1'b1, eb[i], 1'b0}) begin
            n_bad++;
            $display("FAIL wrap_bit%0d got v,b,e=%b want=%b", i,
                     {bit_valid, bit_out, err}, {1'b1, eb[i], 1'b0});
         end
      end
   endtask

   task automatic test_illegal();
      do_reset();
      word_ready = 1'b1;
      step(10);
      step(15);
      step(20);
      step(23);
      n_cmp++;
      if ({err, bit_valid, locked} !== 3'b101) begin
         n_bad++;
         $display("FAIL illegal_err got e,bv,lk=%b want=101", {err, bit_valid, locked});
      end
      step(28);
      n_cmp++;
      if ({err, bit_valid, bit_out} !== 3'b011) begin
         n_bad++;
         $display("FAIL illegal_next got e,bv,b=%b want=011", {err, bit_valid, bit_out});
      end
      for (int v = 27; v >= 21; v--) begin
         step(v);
      end
      n_cmp++;
      if ({word_valid, word_out} !== {1'b1, 8'h01}) begin
         n_bad++;
         $display("FAIL illegal_word got wv=%b w=%h want wv=1 w=01", word_valid, word_out);
      end
   endtask

   task automatic test_upstream_gap();
      int s[7] = '{4, 9, 8, 13, 12, 17, 16};
      do_reset();
      word_ready = 1'b1;
      step(10);
      step(15);
      step(14);
      step(19);
      step(0);
      n_cmp++;
      if ({err, bit_valid, locked} !== 3'b001) begin
         n_bad++;
         $display("FAIL upstream_rst got e,bv,lk=%b want=001", {err, bit_valid, locked});
      end
      idle(4);
      n_cmp++;
      if ({err, bit_valid} !== 2'b00) begin
         n_bad++;
         $display("FAIL gap_quiet got e,bv=%b want=00", {err, bit_valid});
      end
      step(5);
      n_cmp++;
      if ({err, bit_valid, bit_out} !== 3'b011) begin
         n_bad++;
         $display("FAIL gap_bit got e,bv,b=%b want=011", {err, bit_valid, bit_out});
      end
      for (int i = 0; i < 7; i++) begin
         step(s[i]);
      end
      n_cmp++;
      if ({word_valid, word_out} !== {1'b1, 8'h55}) begin
         n_bad++;
         $display("FAIL upstream_word got wv=%b w=%h want wv=1 w=55", word_valid, word_out);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      word_ready = 1'b0;
      step(0);
      for (int k = 1; k <= 8; k++) begin
         step(5 * k);
      end
      n_cmp++;
      if ({word_valid, word_out, overflow} !== {1'b1, 8'hFF, 1'b0}) begin
         n_bad++;
         $display("FAIL ovf_first got wv=%b w=%h ov=%b want 1 ff 0", word_valid, word_out, overflow);
      end
      for (int k = 1; k <= 8; k++) begin
         step(40 - k);
      end
      n_cmp++;
      if ({word_valid, word_out, overflow} !== {1'b1, 8'hFF, 1'b1}) begin
         n_bad++;
         $display("FAIL ovf_drop got wv=%b w=%h ov=%b want 1 ff 1", word_valid, word_out, overflow);
      end
      word_ready = 1'b1;
      idle(1);
      word_ready = 1'b0;
      n_cmp++;
      if ({word_valid, overflow} !== 2'b01) begin
         n_bad++;
         $display("FAIL ovf_sticky got wv,ov=%b want=01", {word_valid, overflow});
      end
      do_reset();
      #1;
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear got=%b want=0", overflow);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      word_ready = 1'b0;
      step(0);
      for (int k = 1; k <= 8; k++) begin
         step(5 * k);
      end
      for (int k = 1; k <= 7; k++) begin
         step(40 - k);
      end
      word_ready = 1'b1;
      step(32);
      word_ready = 1'b0;
      n_cmp++;
      if ({word_valid, word_out, overflow} !== {1'b1, 8'h00, 1'b0}) begin
         n_bad++;
         $display("FAIL b2b_load got wv=%b w=%h ov=%b want 1 00 0", word_valid, word_out, overflow);
      end
   endtask

   task automatic test_reset_mid();
      // Continues from back-to-back: a word is pending and the decoder is locked.
      n_cmp++;
      if ({word_valid, locked} !== 2'b11) begin
         n_bad++;
         $display("FAIL midrst_pre got wv,lk=%b want=11", {word_valid, locked});
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bit_out, bit_valid, word_out, word_valid, locked, err, overflow} !== 14'b0) begin
         n_bad++;
         $display("FAIL midrst_async got=%b want=0",
                  {bit_out, bit_valid, word_out, word_valid, locked, err, overflow});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef COUNT_DECODER_ERRCNT_EN
   task automatic test_errcnt();
      do_reset();
      step(10);
      step(13);
      step(20);
      step(0);
      step(3);
      n_cmp++;
      if (err_count !== 16'd3) begin
         n_bad++;
         $display("FAIL errcnt_count got=%0d want=3", err_count);
      end
      do_reset();
      #1;
      n_cmp++;
      if (err_count !== 16'd0) begin
         n_bad++;
         $display("FAIL errcnt_clear got=%0d want=0", err_count);
      end
   endtask
`endif

   initial begin
      if (((P_INC + P_DEC) % (1 << P_WIDTH)) == 0) begin
         $display("FAIL config INC=%0d DEC=%0d collide mod 2^%0d", P_INC, P_DEC, P_WIDTH);
         $fatal(1, "illegal configuration");
      end
      test_reset();
      test_basic();
      test_wrap();
      test_illegal();
      test_upstream_gap();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef COUNT_DECODER_ERRCNT_EN
      test_errcnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
